// File: rtl/multiport_instruction_memory_pkg.sv
// Shared constants and state encoding for the multi-port instruction store.
package mem_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 6;
    localparam logic [15:0] NOP_WORD   = 16'h0100;

    typedef enum logic {
        MEM_INIT,
        MEM_RUN
    } mem_state_e;

endpackage

// File: rtl/multiport_instruction_memory_if.sv
// Read/write port bundle between the fetch/loader side and the instruction store.
interface multiport_instruction_memory_if
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned RD_PORTS = 4,
    parameter int unsigned WR_PORTS = 4
);

    logic [RD_PORTS*ADDR_W-1:0] rd_addr;
    logic [RD_PORTS-1:0]        rd_en;
    logic [RD_PORTS*DATA_W-1:0] rd_data;
    logic [RD_PORTS-1:0]        rd_valid;
    logic [WR_PORTS*ADDR_W-1:0] wr_addr;
    logic [WR_PORTS*DATA_W-1:0] wr_data;
    logic [WR_PORTS-1:0]        wr_en;
    logic                       init_busy;
    logic                       wr_conflict;
    logic                       wr_dropped;

    modport master (
        output rd_addr, rd_en, wr_addr, wr_data, wr_en,
        input  rd_data, rd_valid, init_busy, wr_conflict, wr_dropped
    );

    modport slave (
        input  rd_addr, rd_en, wr_addr, wr_data, wr_en,
        output rd_data, rd_valid, init_busy, wr_conflict, wr_dropped
    );

endinterface

// File: rtl/multiport_instruction_memory_write_port_arbiter.sv
// Resolves same-address write collisions: highest-indexed enabled port wins.
module write_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned PORTS  = 4,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [PORTS*ADDR_W-1:0] addr_i,
    input  logic [PORTS-1:0]        en_i,
    output logic [PORTS-1:0]        wins_o,
    output logic                    conflict_o
);

    // A port loses if any higher-indexed enabled port targets the same address.
    always_comb begin
        wins_o     = en_i;
        conflict_o = 1'b0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            for (int unsigned q = p + 1; q < PORTS; q++) begin
                if (en_i[p] && en_i[q] &&
                    (addr_i[p*ADDR_W +: ADDR_W] == addr_i[q*ADDR_W +: ADDR_W])) begin
                    wins_o[p]  = 1'b0;
                    conflict_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multiport_instruction_memory.sv
// Multi-port instruction store with sequenced init, optional registered
// write-first reads and write-collision detection.
module multiport_instruction_memory
    import mem_pkg::*;
#(
    parameter int unsigned       DATA_W    = DATA_W_DEF,
    parameter int unsigned       ADDR_W    = ADDR_W_DEF,
    parameter int unsigned       RD_PORTS  = 4,
    parameter int unsigned       WR_PORTS  = 4,
    parameter bit                RD_REG    = 1'b1,
    parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(NOP_WORD)
) (
    input logic                           clock,
    input logic                           reset,
    multiport_instruction_memory_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef logic [ADDR_W:0] cnt_t;

    mem_state_e          state_q, state_d;
    cnt_t                init_cnt_q, init_cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [WR_PORTS-1:0] wins;
    logic                conflict;
    logic                wr_conflict_q;
    logic                wr_dropped_q;
    logic                init_busy;

    write_port_arbiter #(
        .PORTS  (WR_PORTS),
        .ADDR_W (ADDR_W)
    ) u_wr_arb (
        .addr_i     (bus.wr_addr),
        .en_i       (bus.wr_en),
        .wins_o     (wins),
        .conflict_o (conflict)
    );

    assign init_busy       = (state_q == MEM_INIT);
    assign bus.init_busy   = init_busy;
    assign bus.wr_conflict = wr_conflict_q;
    assign bus.wr_dropped  = wr_dropped_q;

    // State and init counter registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= MEM_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Walk the init counter across the array, then hand over to RUN.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == MEM_INIT) begin
            init_cnt_d = init_cnt_q + cnt_t'(1);
            if (init_cnt_q == cnt_t'(DEPTH - 1)) begin
                state_d = MEM_RUN;
            end
        end
    end

    // Array update: init fill during INIT, arbitrated port writes during RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (state_q == MEM_INIT) begin
                mem_q[init_cnt_q[ADDR_W-1:0]] <= INIT_WORD;
            end else begin
                for (int unsigned p = 0; p < WR_PORTS; p++) begin
                    if (wins[p]) begin
                        mem_q[bus.wr_addr[p*ADDR_W +: ADDR_W]] <= bus.wr_data[p*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Status pulses, registered one cycle after the offending write.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_conflict_q <= 1'b0;
            wr_dropped_q  <= 1'b0;
        end else begin
            wr_conflict_q <= (state_q == MEM_RUN) && conflict;
            wr_dropped_q  <= init_busy && (|bus.wr_en);
        end
    end

    if (RD_REG) begin : g_rd_reg
        logic [DATA_W-1:0]   rd_data_q [RD_PORTS];
        logic [DATA_W-1:0]   rd_data_d [RD_PORTS];
        logic [RD_PORTS-1:0] rd_valid_q;
        logic [ADDR_W-1:0]   ra;

        // Write-first: the winning write to a read address bypasses the array.
        always_comb begin
            ra = '0;
            for (int unsigned i = 0; i < RD_PORTS; i++) begin
                rd_data_d[i] = rd_data_q[i];
                ra           = bus.rd_addr[i*ADDR_W +: ADDR_W];
                if (bus.rd_en[i]) begin
                    rd_data_d[i] = mem_q[ra];
                    for (int unsigned p = 0; p < WR_PORTS; p++) begin
                        if (wins[p] && (bus.wr_addr[p*ADDR_W +: ADDR_W] == ra)) begin
                            rd_data_d[i] = bus.wr_data[p*DATA_W +: DATA_W];
                        end
                    end
                end
            end
        end

        // Read registers: only RUN produces valid data, INIT holds contents.
        always_ff @(posedge clock) begin
            if (!reset) begin
                rd_valid_q <= '0;
                for (int unsigned i = 0; i < RD_PORTS; i++) begin
                    rd_data_q[i] <= INIT_WORD;
                end
            end else if (state_q == MEM_RUN) begin
                rd_valid_q <= bus.rd_en;
                for (int unsigned i = 0; i < RD_PORTS; i++) begin
                    rd_data_q[i] <= rd_data_d[i];
                end
            end else begin
                rd_valid_q <= '0;
            end
        end

        assign bus.rd_valid = rd_valid_q;
        for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd_out
            assign bus.rd_data[g*DATA_W +: DATA_W] = rd_data_q[g];
        end
    end else begin : g_rd_comb
        assign bus.rd_valid = bus.rd_en & {RD_PORTS{~init_busy}};
        for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd_out
            assign bus.rd_data[g*DATA_W +: DATA_W] = mem_q[bus.rd_addr[g*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: doc/multiport_instruction_memory.md
Name: multiport_instruction_memory

Overview:
- Parametrised multi-port instruction store for the pipeline fetch/load path.
- Provides RD_PORTS read and WR_PORTS write ports into a DEPTH x DATA_W array.
- Adds three things:
  - a sequenced post-reset initialisation, one word per cycle;
  - optional registered reads with write-first forwarding;
  - detection of same-address write collisions.
- Sits between the fetch/decode stages (read side) and the program loader/debug path (write side).

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W.
- RD_PORTS, 4, number of read ports (1..8).
- WR_PORTS, 4, number of write ports (1..8).
- RD_REG, 1: 1 = registered reads (1-cycle latency); 0 = combinational reads.
- INIT_WORD, 16'h0100, value written to every location during initialisation.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- rd_addr  in  RD_PORTS*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_en  in  RD_PORTS  per-port read request.
- rd_data  out  RD_PORTS*DATA_W  packed read data.
- rd_valid  out  RD_PORTS  per-port read data valid.
- wr_addr  in  WR_PORTS*ADDR_W  packed write addresses.
- wr_data  in  WR_PORTS*DATA_W  packed write data.
- wr_en  in  WR_PORTS  per-port write enable.
- init_busy  out  1  high while the array is being initialised.
- wr_conflict  out  1  one-cycle pulse: two or more enabled writes targeted the same address.
- wr_dropped  out  1  one-cycle pulse: a write was discarded because init_busy was high.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state <= INIT; init_cnt <= 0; init_busy <= 1.
  - rd_valid, wr_conflict and wr_dropped <= 0; rd_data registers <= INIT_WORD.
  - No array writes occur while reset is held low.
- State machine, two states: INIT and RUN.
  - INIT, each cycle with reset==1: mem[init_cnt] <= INIT_WORD; init_cnt++.
  - When init_cnt==DEPTH-1, that write completes and state <= RUN; init_busy reads 0 from the following cycle.
  - init_busy is therefore high for exactly DEPTH cycles after reset deasserts.
- Reset asserted during INIT restarts the count from 0.
- Reset asserted in RUN re-enters INIT and clears the whole array again.
- Writes during INIT:
  - Every wr_en bit is ignored; the array is unchanged by the ports.
  - wr_dropped pulses (registered, next cycle) if any wr_en bit was high.
  - Reads during INIT: rd_valid stays 0 and rd_data holds INIT_WORD.
- Writes in RUN:
  - All enabled ports commit in the same cycle.
  - Collision priority: when several enabled ports share an address, the highest-indexed port wins.
  - wr_conflict pulses the cycle after any such collision. Collision detection uses pairwise address compare across enabled ports.
- Reads in RUN with RD_REG=1:
  - rd_data[i] and rd_valid[i] are registered; latency is 1 cycle.
  - rd_valid[i] <= rd_en[i].
  - Write-first: if the same-cycle winning write targets rd_addr[i], rd_data[i] returns the new write data.
  - When rd_en[i]==0, rd_data[i] holds its previous value.
- Reads in RUN with RD_REG=0:
  - rd_data[i] = mem[rd_addr[i]] combinationally, showing pre-write contents; rd_valid[i] = rd_en[i] & ~init_busy.
  - No forwarding.
- Address range: all ADDR_W values are legal (DEPTH is a power of two), so no out-of-range handling is needed.
- Unsigned arithmetic throughout. init_cnt is ADDR_W+1 bits wide so the terminal compare does not wrap.

Decomposition:
- Shared package mem_pkg holds:
  - state encoding (MEM_INIT, MEM_RUN);
  - default DATA_W/ADDR_W constants;
  - NOP_WORD = 16'h0100 (the INIT_WORD default).
- One natural sub-module: write_port_arbiter.
  - Inputs: WR_PORTS addresses and enables.
  - Outputs: a per-port "wins" mask and a conflict flag.
  - The same logic is reused for the forwarding select in the read path.

Test Plan:
- Init sequencing: hold reset=0 for 3 cycles, release.
  - init_busy is high for exactly 64 cycles.
  - Afterwards, reads of addresses 0, 31 and 63 on all four ports return 16'h0100 one cycle after rd_en, with rd_valid=1.
- Parallel writes: in RUN, write 0x1111@5, 0x2222@6, 0x3333@7, 0x4444@8 on ports 0-3 in one cycle.
  - Next cycle, ports 0-3 read addresses 5-8 and return those values after 1 cycle.
  - wr_conflict stays 0.
- Collision: ports 0, 2 and 3 write 0xAAAA, 0xBBBB and 0xCCCC to address 12 in the same cycle.
  - wr_conflict pulses for exactly 1 cycle.
  - A subsequent read of address 12 returns 0xCCCC.
- Write-first forwarding (RD_REG=1): port 1 writes 0x5A5A@20 while rd port 2 reads @20 in the same cycle.
  - rd_data[2] = 0x5A5A on the next cycle.
  - With RD_REG=0, the same stimulus returns the old value (0x0100).
- Dropped write: assert wr_en[0] with 0xDEAD@3 on cycle 10 of INIT.
  - wr_dropped pulses on cycle 11.
  - After INIT completes, a read of address 3 returns 0x0100.
- Reset mid-operation: write 0x7777@40 in RUN, then pulse reset=0 for 1 cycle.
  - init_busy rises and lasts 64 cycles.
  - A read of address 40 afterwards returns 0x0100.
  - A second reset asserted at INIT cycle 30 restarts the count, so the total busy time is 64 cycles from the final release.
